// File: rtl/jtdd_romarb_pkg.sv
// Shared constants for the graphics ROM arbiter:
// FSM encoding, requester slot indices and SDRAM address width.
package jtdd_romarb_pkg;

  localparam int SDRAM_AW = 22;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  localparam logic [1:0] CHAR = 2'd0;
  localparam logic [1:0] SCR  = 2'd1;
  localparam logic [1:0] OBJ  = 2'd2;

endpackage

// File: rtl/jtdd_romarb_slot.sv
// One-entry cache for a ROM requester: latched address,
// valid bit and data word, with hit/ok/pending flags.
module jtdd_romarb_slot #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic [15:0]   data,
  output logic          ok,
  output logic          pending
);

  logic [AW-1:0] lat_addr;
  logic          valid;
  logic          hit;

  assign hit     = valid && (addr == lat_addr);
  assign ok      = cs && hit;
  assign pending = cs && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      lat_addr <= '0;
      data     <= '0;
    end else if (we) begin
      valid    <= 1'b1;
      lat_addr <= wr_addr;
      data     <= wr_data;
    end
  end

endmodule

// File: rtl/jtdd_gfx_romarb.sv
// Char/scroll/object ROM arbiter onto one SDRAM read port.
// Define JTDD_ROMARB_RR_EN for round-robin grants.
module jtdd_gfx_romarb
  import jtdd_romarb_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h08000,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h28000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         char_addr,
  input  logic                char_cs,
  output logic [7:0]          char_data,
  output logic                char_ok,
  input  logic [16:0]         scr_addr,
  input  logic                scr_cs,
  output logic [15:0]         scr_data,
  output logic                scr_ok,
  input  logic [18:0]         obj_addr,
  input  logic                obj_cs,
  output logic [15:0]         obj_data,
  output logic                obj_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);

  logic [1:0]          state;
  logic [1:0]          gnt;
  logic [1:0]          sel;
  logic [18:0]         gnt_addr;
  logic [18:0]         sel_addr;
  logic [SDRAM_AW-1:0] sel_off;
  logic [2:0]          pend;
  logic [2:0]          wr;
  logic [15:0]         char_word;
  logic                done;

  assign done = (state == ST_WAIT_ACK  && sdram_ack && data_rdy)
             || (state == ST_WAIT_DATA && data_rdy);
  assign wr   = done ? (3'b001 << gnt) : 3'b000;

  jtdd_romarb_slot #(.AW(15)) u_char (
    .clk     (clk),
    .rst     (rst),
    .addr    (char_addr[15:1]),
    .cs      (char_cs),
    .we      (wr[CHAR]),
    .wr_addr (gnt_addr[14:0]),
    .wr_data (data_read),
    .data    (char_word),
    .ok      (char_ok),
    .pending (pend[CHAR])
  );

  jtdd_romarb_slot #(.AW(17)) u_scr (
    .clk     (clk),
    .rst     (rst),
    .addr    (scr_addr),
    .cs      (scr_cs),
    .we      (wr[SCR]),
    .wr_addr (gnt_addr[16:0]),
    .wr_data (data_read),
    .data    (scr_data),
    .ok      (scr_ok),
    .pending (pend[SCR])
  );

  jtdd_romarb_slot #(.AW(19)) u_obj (
    .clk     (clk),
    .rst     (rst),
    .addr    (obj_addr),
    .cs      (obj_cs),
    .we      (wr[OBJ]),
    .wr_addr (gnt_addr),
    .wr_data (data_read),
    .data    (obj_data),
    .ok      (obj_ok),
    .pending (pend[OBJ])
  );

  assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];

`ifdef JTDD_ROMARB_RR_EN
  logic [1:0] last;

  // Search starts at the slot after the last one granted
  always_comb begin
    sel = CHAR;
    unique case (last)
      CHAR:    sel = pend[SCR]  ? SCR  : pend[OBJ] ? OBJ : CHAR;
      SCR:     sel = pend[OBJ]  ? OBJ  : pend[CHAR] ? CHAR : SCR;
      default: sel = pend[CHAR] ? CHAR : pend[SCR] ? SCR : OBJ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= OBJ;
    else if (state == ST_IDLE && |pend)
      last <= sel;
  end
`else
  always_comb begin
    sel = pend[CHAR] ? CHAR : pend[SCR] ? SCR : OBJ;
  end
`endif

  always_comb begin
    sel_addr = obj_addr;
    sel_off  = OBJ_OFFSET;
    unique case (sel)
      CHAR: begin
        sel_addr = {4'd0, char_addr[15:1]};
        sel_off  = CHAR_OFFSET;
      end
      SCR: begin
        sel_addr = {2'd0, scr_addr};
        sel_off  = SCR_OFFSET;
      end
      default: begin
        sel_addr = obj_addr;
        sel_off  = OBJ_OFFSET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= CHAR;
      gnt_addr   <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (|pend) begin
          gnt        <= sel;
          gnt_addr   <= sel_addr;
          sdram_addr <= sel_off + {3'd0, sel_addr};
          sdram_req  <= 1'b1;
          state      <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: if (sdram_ack) begin
          sdram_req <= 1'b0;
          state     <= data_rdy ? ST_IDLE : ST_WAIT_DATA;
        end
        ST_WAIT_DATA: if (data_rdy) begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_romarb.sv
// Bench for jtdd_gfx_romarb: directed steps plus random traffic
// checked against a per-slot cache model with priority search.
module tb_jtdd_gfx_romarb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] char_addr = '0;
  logic        char_cs = 1'b0;
  logic [7:0]  char_data;
  logic        char_ok;
  logic [16:0] scr_addr = '0;
  logic        scr_cs = 1'b0;
  logic [15:0] scr_data;
  logic        scr_ok;
  logic [18:0] obj_addr = '0;
  logic        obj_cs = 1'b0;
  logic [15:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [15:0] data_read = '0;

  int nvec = 0;
  int nerr = 0;

  logic [21:0] offs [3] = '{22'h00000, 22'h08000, 22'h28000};
  logic        m_val  [3];
  logic [18:0] m_addr [3];
  logic [15:0] m_data [3];
  int          m_last;

  jtdd_gfx_romarb dut (
    .clk        (clk),
    .rst        (rst),
    .char_addr  (char_addr),
    .char_cs    (char_cs),
    .char_data  (char_data),
    .char_ok    (char_ok),
    .scr_addr   (scr_addr),
    .scr_cs     (scr_cs),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_addr   (obj_addr),
    .obj_cs     (obj_cs),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] cur_addr(input int i);
    case (i)
      0:       return {4'd0, char_addr[15:1]};
      1:       return {2'd0, scr_addr};
      default: return obj_addr;
    endcase
  endfunction

  function automatic logic cur_cs(input int i);
    case (i)
      0:       return char_cs;
      1:       return scr_cs;
      default: return obj_cs;
    endcase
  endfunction

  function automatic logic hitm(input int i);
    return m_val[i] && (m_addr[i] == cur_addr(i));
  endfunction

  function automatic int pick();
    int start = 0;
`ifdef JTDD_ROMARB_RR_EN
    start = (m_last + 1) % 3;
`endif
    for (int k = 0; k < 3; k++) begin
      int j = (start + k) % 3;
      if (cur_cs(j) && !hitm(j)) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_val[i]  = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_last = 2;
  endtask

  task automatic check_outs(input string tag);
    logic [15:0] cw;
    cw = m_data[0];
    chk({tag, " char_ok"}, char_ok, char_cs && hitm(0));
    chk({tag, " char_data"}, char_data,
        char_addr[0] ? cw[15:8] : cw[7:0]);
    chk({tag, " scr_ok"}, scr_ok, scr_cs && hitm(1));
    chk({tag, " scr_data"}, scr_data, m_data[1]);
    chk({tag, " obj_ok"}, obj_ok, obj_cs && hitm(2));
    chk({tag, " obj_data"}, obj_data, m_data[2]);
  endtask

  // Controller side: request seen, optional ack delay, then data.
  task automatic serve(input string tag, input logic [21:0] ea,
                       input logic [15:0] d, input int lat,
                       input int ackd);
    int n = 0;
    while (!sdram_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, " req latency"}, n, 1);
    chk({tag, " req"}, sdram_req, 1'b1);
    chk({tag, " addr"}, sdram_addr, ea);
    repeat (ackd) begin
      step();
      chk({tag, " req held"}, sdram_req, 1'b1);
      chk({tag, " addr held"}, sdram_addr, ea);
    end
    sdram_ack = 1'b1;
    if (lat == 0) begin
      data_rdy  = 1'b1;
      data_read = d;
    end
    step();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    chk({tag, " req drop"}, sdram_req, 1'b0);
    if (lat > 0) begin
      repeat (lat - 1) step();
      data_rdy  = 1'b1;
      data_read = d;
      step();
      data_rdy  = 1'b0;
    end
  endtask

  task automatic txn(input string tag, input logic [15:0] d,
                     input int lat, input int ackd);
    int g;
    logic [18:0] ga;
    g = pick();
    if (g < 0) begin
      step();
      chk({tag, " idle req"}, sdram_req, 1'b0);
      check_outs(tag);
      return;
    end
    ga = cur_addr(g);
    serve(tag, offs[g] + {3'd0, ga}, d, lat, ackd);
    m_val[g]  = 1'b1;
    m_addr[g] = ga;
    m_data[g] = d;
    m_last    = g;
    check_outs(tag);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) step();
    chk("rst req", sdram_req, 1'b0);
    chk("rst addr", sdram_addr, 22'd0);
    check_outs("rst");
    rst = 1'b0;

    // Char word fetch, then byte select from the cached word
    char_cs   = 1'b1;
    char_addr = 16'h0003;
    txn("t1", 16'hA55A, 2, 0);
    chk("t1 byte hi", char_data, 8'hA5);
    char_addr = 16'h0002;
    #1;
    chk("t1 byte lo", char_data, 8'h5A);
    chk("t1 ok lo", char_ok, 1'b1);
    repeat (3) begin
      step();
      chk("t1 no req", sdram_req, 1'b0);
    end

    // Scroll and object both pending
    char_cs  = 1'b0;
    scr_cs   = 1'b1;
    scr_addr = 17'($urandom_range(32, 65535));
    obj_cs   = 1'b1;
    obj_addr = 19'($urandom_range(32, 262143));
    txn("t2a", 16'($urandom), 1, 1);
    txn("t2b", 16'($urandom), 3, 0);
    chk("t2 scr ok", scr_ok, 1'b1);
    chk("t2 obj ok", obj_ok, 1'b1);

    // Object address moves while the fetch is in flight
    scr_cs   = 1'b0;
    obj_addr = 19'h00010;
    step();
    chk("t4 req", sdram_req, 1'b1);
    chk("t4 addr", sdram_addr, 22'h28010);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    obj_addr  = 19'h00011;
    step();
    chk("t4 ok wait", obj_ok, 1'b0);
    data_rdy  = 1'b1;
    data_read = 16'h1234;
    step();
    data_rdy  = 1'b0;
    m_val[2]  = 1'b1;
    m_addr[2] = 19'h00010;
    m_data[2] = 16'h1234;
    m_last    = 2;
    chk("t4 ok stale", obj_ok, 1'b0);
    obj_addr = 19'h00010;
    #1;
    chk("t4 ok old", obj_ok, 1'b1);
    chk("t4 data old", obj_data, 16'h1234);
    obj_addr = 19'h00011;
    #1;
    txn("t4b", 16'h4321, 1, 0);

    // Ack and data in the same cycle
    obj_cs    = 1'b0;
    char_cs   = 1'b1;
    char_addr = 16'h0101;
    txn("t5", 16'hC3E1, 0, 0);
    step();
    chk("t5 no extra req", sdram_req, 1'b0);

    // All three busy with addresses moving after every grant
    for (int i = 0; i < 6; i++) begin
      char_cs   = 1'b1;
      scr_cs    = 1'b1;
      obj_cs    = 1'b1;
      char_addr = char_addr + 16'd2;
      scr_addr  = scr_addr + 17'd1;
      obj_addr  = obj_addr + 19'd1;
      txn("t3", 16'($urandom), $urandom_range(0, 2), 0);
    end

    for (int i = 0; i < 40; i++) begin
      char_cs   = 1'($urandom);
      scr_cs    = 1'($urandom);
      obj_cs    = 1'($urandom);
      char_addr = 16'($urandom_range(0, 5));
      scr_addr  = 17'($urandom_range(0, 2)) + 17'h1FFFC;
      obj_addr  = ($urandom_range(0, 1) != 0 ? 19'h7FFFF : 19'h00000)
                ^ 19'($urandom_range(0, 2));
      #1;
      check_outs("rnd pre");
      txn("rnd", 16'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 2));
    end

    // Reset in WAIT_DATA, then a late data_rdy
    step();
    char_cs  = 1'b0;
    scr_cs   = 1'b0;
    obj_cs   = 1'b1;
    obj_addr = 19'h00155;
    step();
    if (!sdram_req) step();
    chk("t6 req", sdram_req, 1'b1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    rst    = 1'b1;
    obj_cs = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    chk("t6 req rst", sdram_req, 1'b0);
    check_outs("t6 rst");
    data_rdy  = 1'b1;
    data_read = 16'hBEEF;
    step();
    data_rdy = 1'b0;
    chk("t6 req late", sdram_req, 1'b0);
    obj_cs = 1'b1;
    #1;
    chk("t6 obj ok", obj_ok, 1'b0);
    chk("t6 obj data", obj_data, 16'h0000);
    check_outs("t6 end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
